// File: rtl/sw_debounce.sv
// sw_debounce: conditions the board slide switches (Sel, n[3:0]) for the
// general-purpose input word. Each bit has a 2-FF synchroniser and a
// stability counter. sw_out only flips after the synchronised input has
// disagreed with it for STABLE_CYCLES consecutive clocks. chg/chg_mask
// pulse for one cycle on every commit.
// Optional build macro SW_DEBOUNCE_EDGE_EN adds the rise/fall commit pulses.
module sw_debounce #(
    parameter int unsigned WIDTH         = 5,
    parameter int unsigned STABLE_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             chg,
    output logic [WIDTH-1:0] chg_mask
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] commit;

    // Two-stage synchroniser for the asynchronous switch levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // A bit commits once it has mismatched for STABLE_CYCLES samples in a row
    always_comb begin
        mismatch = s2 ^ sw_out;
        commit   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            commit[i] = mismatch[i] && (cnt[i] == CNT_MAX);
        end
    end

    // Per-bit stability counters: cleared on agreement or on commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (!mismatch[i] || commit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registered outputs; a committing bit always takes s2, i.e. toggles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_out   <= '0;
            chg_mask <= '0;
            chg      <= 1'b0;
        end else begin
            sw_out   <= sw_out ^ commit;
            chg_mask <= commit;
            chg      <= |commit;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    // Direction of each commit, aligned with chg
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= commit & ~sw_out;
            fall <= commit & sw_out;
        end
    end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (WIDTH=5, STABLE_CYCLES=4).
// The reference model works on the recorded input/reset history: a bit
// commits at edge k when the synchronised sample seen at each of the last
// STABLE_CYCLES edges disagreed with the committed value and none of those
// edges is at or before the bit's last commit/reset.
module tb_sw_debounce;

    localparam int W    = 5;
    localparam int S    = 4;
    localparam int MAXE = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic         chg;
    logic [W-1:0] chg_mask;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [W-1:0] rise;
    logic [W-1:0] fall;
`endif

    sw_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .chg     (chg),
        .chg_mask(chg_mask)
`ifdef SW_DEBOUNCE_EDGE_EN
        ,
        .rise    (rise),
        .fall    (fall)
`endif
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           k;
        logic [W-1:0] mask;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] in_hist [MAXE];
    logic         rst_hist[MAXE];
    logic [W-1:0] exp_out [MAXE];
    logic [W-1:0] out_m;
    int           last_c  [W];
    logic [W-1:0] cur;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge %0d: got %b expected %b", name, edge_n, got, want);
        end
    endtask

    // Value the counter logic sees at edge j (s2 before that edge)
    function automatic logic [W-1:0] syn(input int j);
        if (j < 2) return '0;
        if (!rst_hist[j-1] || !rst_hist[j-2]) return '0;
        return in_hist[j-2];
    endfunction

    // Drive inputs for the coming edge and predict its outcome
    task automatic apply(input logic r, input logic [W-1:0] v);
        int           k;
        logic [W-1:0] m;
        logic [W-1:0] sv;
        bit           ok;
        exp_t         e;
        k   = edge_n;
        m   = '0;
        rst = r;
        sw_in = v;
        cur = v;
        in_hist[k]  = v;
        rst_hist[k] = r;
        if (!r) begin
            out_m = '0;
            for (int i = 0; i < W; i++) last_c[i] = k;
        end else begin
            for (int i = 0; i < W; i++) begin
                ok = 1'b1;
                for (int j = k - S + 1; j <= k; j++) begin
                    sv = syn(j);
                    if (j <= last_c[i] || sv[i] == out_m[i]) ok = 1'b0;
                end
                m[i] = ok;
            end
            if (m != '0) begin
                e.k    = k;
                e.mask = m;
                e.rise = m & ~out_m;
                e.fall = m & out_m;
                sb.push_back(e);
                out_m = out_m ^ m;
                for (int i = 0; i < W; i++) if (m[i]) last_c[i] = k;
            end
        end
        exp_out[k] = out_m;
    endtask

    task automatic step(input logic r, input logic [W-1:0] v);
        apply(r, v);
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b1, cur);
    endtask

    // Monitor: per-edge level check, chg events popped from the scoreboard
    initial begin : monitor
        int   k;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            k = edge_n - 1;
            check("sw_out", sw_out, exp_out[k]);
            if (chg) begin
                if (sb.size() == 0 || sb[0].k != k) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chg edge %0d: got chg=1 mask %b expected chg=0", k, chg_mask);
                end else begin
                    e = sb.pop_front();
                    check("chg_mask", chg_mask, e.mask);
`ifdef SW_DEBOUNCE_EDGE_EN
                    check("rise", rise, e.rise);
                    check("fall", fall, e.fall);
`endif
                end
            end else begin
                check("chg_mask_idle", chg_mask, '0);
`ifdef SW_DEBOUNCE_EDGE_EN
                check("rise_idle", rise, '0);
                check("fall_idle", fall, '0);
`endif
                if (sb.size() != 0 && sb[0].k <= k) begin
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_chg edge %0d: got chg=0 expected chg=1 mask %b", k, e.mask);
                end
            end
        end
    end

    initial begin : stimulus
        logic [W-1:0] v;
        out_m = '0;
        for (int i = 0; i < W; i++) last_c[i] = -1;

        // Reset held with switches already set, then release
        for (int i = 0; i < 3; i++) step(1'b0, 5'b10110);
        hold(10);
        check("after_release", sw_out, 5'b10110);

        // Three-cycle glitch on bit 0 is rejected
        for (int i = 0; i < 3; i++) step(1'b1, 5'b10111);
        step(1'b1, 5'b10110);
        hold(10);
        check("glitch_rejected", sw_out, 5'b10110);

        // Clear, then single-bit rise on bit 2
        step(1'b1, 5'b00000);
        hold(10);
        step(1'b1, 5'b00100);
        hold(10);
        check("bit2_rise", sw_out, 5'b00100);

        // Bits 3 and 1 together
        step(1'b1, 5'b01110);
        hold(10);
        check("bits31", sw_out, 5'b01110);

        // Bit 4 toggles every 2 cycles, then settles high
        for (int c = 0; c < 40; c++) begin
            v = cur;
            v[4] = ((c / 2) % 2 == 0);
            step(1'b1, v);
        end
        check("toggle_frozen", sw_out, 5'b01110);
        step(1'b1, 5'b11110);
        hold(10);
        check("bit4_settled", sw_out, 5'b11110);

        // Reset two cycles into a debounce: outputs clear without a clock edge
        step(1'b1, 5'b11111);
        step(1'b1, 5'b11111);
        apply(1'b0, 5'b11111);
        #1;
        check("async_rst_sw_out", sw_out, '0);
        check("async_rst_chg", {4'b0, chg}, '0);
        @(negedge clk);
        step(1'b0, 5'b11111);
        hold(12);
        check("after_rst_restart", sw_out, 5'b11111);

        // Randomised run with occasional resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1'b0, cur);
                step(1'b0, cur);
            end else begin
                v = cur;
                if ($urandom_range(0, 9) < 2) v[$urandom_range(0, W - 1)] ^= 1'b1;
                if ($urandom_range(0, 29) == 0) v = W'($urandom);
                step(1'b1, v);
            end
        end
        hold(10);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: got %0d pending events expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Upstream conditioning stage for the board slide switches (Sel, n[3:0]) before they are packed into the system's general-purpose input word.
- Runs on the 5 kHz display/system clock. Each switch bit passes through a 2-FF synchroniser and a per-bit stability counter.
- Emits clean, glitch-free levels plus a one-cycle change strobe, which the top level may use as a "new operand" event.

Parameters:
- WIDTH, 5, number of independent switch bits (bit 4 = Sel, bits 3:0 = n).
- STABLE_CYCLES, 20, consecutive clk cycles a synchronised input must differ from the committed output before the output flips (20 cycles = 4 ms at 5 kHz); legal range 2..255.
- CNT_W (localparam), $clog2(STABLE_CYCLES), counter width; not overridable.

Ports:
- clk  input  1  system clock (5 kHz in the FPGA build).
- rst  input  1  asynchronous, active-low reset.
- sw_in  input  WIDTH  raw asynchronous switch levels.
- sw_out  output  WIDTH  debounced, registered switch levels.
- chg  output  1  one-cycle pulse: at least one bit of sw_out changed on this edge.
- chg_mask  output  WIDTH  bits of sw_out that changed on this edge; all-zero when chg=0.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-safe deassert by design): sync stages=0, all counters=0, sw_out=0, chg=0, chg_mask=0. Any debounce in progress is discarded.
- Synchroniser, per bit i: s1[i] <= sw_in[i]; s2[i] <= s1[i]. Only s2 feeds the counter logic.
- Counter, per bit, evaluated every rising clk edge:
  - s2[i]==sw_out[i]: cnt[i] <= 0; sw_out[i] holds.
  - s2[i]!=sw_out[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i]!=sw_out[i] and cnt[i]==STABLE_CYCLES-1: sw_out[i] <= s2[i]; cnt[i] <= 0; chg_mask[i] <= 1.
- chg_mask[i] is 0 on every edge where bit i does not commit. chg = |chg_mask; it is registered in the same edge as the sw_out update.
- Latency: if sw_in changes before edge 0 and stays stable, sw_out changes on edge STABLE_CYCLES+1 (2 sync edges plus STABLE_CYCLES mismatch samples, first sample overlapping). chg is high for exactly the cycle after that edge.
- Glitch rejection: a mismatch seen at s2 for fewer than STABLE_CYCLES consecutive cycles clears the counter and never reaches sw_out.
- Bits are fully independent. Simultaneous commits on several bits produce a single chg pulse with multiple chg_mask bits set.
- Continuous toggling faster than STABLE_CYCLES keeps sw_out frozen indefinitely.
- The counter never wraps; it saturates logically at STABLE_CYCLES-1, where the commit occurs.
- Per-bit counters, FSM-free. Roughly 120–180 lines including the optional feature.

Optional Feature:
- Macro SW_DEBOUNCE_EDGE_EN.
- Defined: adds output ports rise[WIDTH] and fall[WIDTH]. On a commit edge, rise[i]=1 if sw_out[i] went 0→1 and fall[i]=1 if it went 1→0; both are one-cycle pulses aligned with chg. Both reset to 0.
- Undefined: ports and logic absent; chg and chg_mask behave identically in both builds.

Test Plan (STABLE_CYCLES=4, WIDTH=5):
- Reset release with sw_in=5'b10110 held -> sw_out=0 through reset; after release sw_out=5'b10110 on edge 5, chg=1 for one cycle with chg_mask=5'b10110.
- sw_in[0] pulses high for 3 cycles (aligned to clk), otherwise 0 -> sw_out[0] stays 0, chg never asserts.
- sw_in[2] 0→1 held -> sw_out[2]=1 exactly on edge 5 after the change. chg_mask=5'b00100 for one cycle; with SW_DEBOUNCE_EDGE_EN, rise=5'b00100 and fall=0.
- Bits 3 and 1 flip on the same edge -> a single chg pulse with chg_mask=5'b01010, both sw_out bits updating on the same edge.
- Bit 4 toggles every 2 cycles for 40 cycles, then settles at 1 -> sw_out[4] unchanged during toggling, then commits to 1 on edge 5 after settling.
- rst asserted at cycle 2 of a 4-cycle debounce -> outputs zero immediately (asynchronous). After release the full STABLE_CYCLES+1 latency restarts from scratch.
